// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Central hazard and stall controller for the 16-bit 5-stage pipeline.
//   It watches the register fields and control bits of the D/E/M/W stages and
//   the data-memory handshake. From these it drives the stall/flush/hold
//   controls for the pipeline registers and the E-stage forwarding selects.
//   A small FSM tracks multi-cycle memory waits and raises a sticky timeout.
//   Two saturating counters record stall cycles and branch flush events.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   rs_d, rt_d,         D-stage source registers; rt_d is only used when
//   uses_rt_d           uses_rt_d is set
//   rs_e, rt_e, rd_e,   E-stage sources and destination, write enable,
//   write_reg_e,        load flag and taken-branch resolution
//   load_e,
//   branch_taken_e
//   rd_m, write_reg_m,  M-stage destination and write enable; data-memory
//   mem_req_m,          request and completion
//   mem_ready
//   rd_w, write_reg_w   W-stage destination and write enable
//   clr_cnt             synchronous clear of both performance counters
//   stall_f, stall_d    hold PC / hold D register
//   flush_d, flush_e    bubble D / bubble E register
//   hold_em             hold E and M registers
//   fwd_a_e, fwd_b_e    ALU operand selects: 00 reg file, 01 W, 10 M
//   mem_err             sticky memory timeout flag
//   stall_cnt           cycles with stall_f=1 (saturating)
//   flush_cnt           branch flush events taken from RUN (saturating)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_W    = 3,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 16,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             uses_rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             write_reg_e,
  input  logic             load_e,
  input  logic             branch_taken_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic             write_reg_m,
  input  logic             mem_req_m,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] rd_w,
  input  logic             write_reg_w,
  input  logic             clr_cnt,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             hold_em,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int              WC_W   = $clog2(MAX_WAIT) + 1;
  localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WC_W-1:0]  r_wait_cnt;
  logic [WC_W-1:0]  w_wait_cnt_next;
  logic             r_mem_err;
  logic             w_mem_err_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_memhold;
  logic             w_loaduse;
  logic             w_branch_win;
  logic             w_stall_f;
  logic             w_stall_d;
  logic             w_flush_d;
  logic             w_flush_e;
  logic             w_hold_em;

  // Register equality, with register 0 optionally treated as a hard-wired
  // zero that never produces a dependency.
  function automatic logic f_match(input logic [REG_W-1:0] x,
                                   input logic [REG_W-1:0] y);
    f_match = (x == y) && !((ZERO_REG != 0) && (x == '0));
  endfunction

  // ---------------------------------------------------------------------------
  // Forwarding: both ALU operands share the same selection rule, M before W.
  // ---------------------------------------------------------------------------
  logic [REG_W-1:0] w_src_e   [2];
  logic [1:0]       w_fwd_sel [2];

  assign w_src_e[0] = rs_e;
  assign w_src_e[1] = rt_e;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      assign w_fwd_sel[gi] =
        (write_reg_m && f_match(rd_m, w_src_e[gi])) ? 2'b10 :
        (write_reg_w && f_match(rd_w, w_src_e[gi])) ? 2'b01 :
                                                      2'b00;
    end
  endgenerate

  assign fwd_a_e = w_fwd_sel[0];
  assign fwd_b_e = w_fwd_sel[1];

  // ---------------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------------
  assign w_memhold = mem_req_m && !mem_ready;
  assign w_loaduse = load_e && write_reg_e &&
                     (f_match(rd_e, rs_d) || (uses_rt_d && f_match(rd_e, rt_d)));

  // ---------------------------------------------------------------------------
  // FSM state register and sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_mem_err  <= w_mem_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control outputs (no latency on the controls)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_mem_err_next  = r_mem_err;
    w_stall_f       = 1'b0;
    w_stall_d       = 1'b0;
    w_flush_d       = 1'b0;
    w_flush_e       = 1'b0;
    w_hold_em       = 1'b0;
    w_branch_win    = 1'b0;

    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        // A held memory access freezes everything; branch and load-use are
        // re-evaluated after release because the stage inputs are held.
        if (w_memhold) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_hold_em = 1'b1;
        end else if (branch_taken_e) begin
          w_flush_d    = 1'b1;
          w_flush_e    = 1'b1;
          w_branch_win = 1'b1;
        end else if (w_loaduse) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      ST_TIMEOUT: begin
        w_stall_f = 1'b1;
        w_stall_d = 1'b1;
        w_hold_em = 1'b1;
      end
      default: begin
      end
    endcase

    case (r_state)
      ST_RUN: begin
        if (w_memhold) begin
          w_wait_cnt_next = WC_ONE;
          if (MAX_WAIT <= 1) begin
            w_state_next   = ST_TIMEOUT;
            w_mem_err_next = 1'b1;
          end else begin
            w_state_next = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        // The ready cycle is not held; the wait ends on that edge.
        if (mem_ready) begin
          w_state_next    = ST_RUN;
          w_wait_cnt_next = '0;
        end else if (r_wait_cnt + WC_ONE == WC_MAX) begin
          w_state_next   = ST_TIMEOUT;
          w_mem_err_next = 1'b1;
        end else begin
          w_wait_cnt_next = r_wait_cnt + WC_ONE;
        end
      end
      ST_TIMEOUT: begin
        // Only reset leaves this state.
      end
      default: begin
        w_state_next    = ST_RUN;
        w_wait_cnt_next = '0;
      end
    endcase

    // Reset dominates the controls immediately, independent of the clock.
    if (rst) begin
      w_stall_f    = 1'b0;
      w_stall_d    = 1'b0;
      w_flush_d    = 1'b0;
      w_flush_e    = 1'b0;
      w_hold_em    = 1'b0;
      w_branch_win = 1'b0;
    end
  end

  assign stall_f = w_stall_f;
  assign stall_d = w_stall_d;
  assign flush_d = w_flush_d;
  assign flush_e = w_flush_e;
  assign hold_em = w_hold_em;
  assign mem_err = r_mem_err;

  // ---------------------------------------------------------------------------
  // Saturating performance counters; clear wins over increment.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (clr_cnt) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      // Only branches that win priority while in RUN are counted.
      if ((r_state == ST_RUN) && w_branch_win && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl with small parameters
//   (MAX_WAIT=4, CNT_W=4) so timeout and counter saturation are reachable.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int REG_W    = 3;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  logic             clk;
  logic             rst;
  logic [REG_W-1:0] rs_d, rt_d, rs_e, rt_e, rd_e, rd_m, rd_w;
  logic             uses_rt_d, write_reg_e, load_e, branch_taken_e;
  logic             write_reg_m, mem_req_m, mem_ready, write_reg_w, clr_cnt;
  logic             stall_f, stall_d, flush_d, flush_e, hold_em, mem_err;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .REG_W   (REG_W),
    .CNT_W   (CNT_W),
    .MAX_WAIT(MAX_WAIT),
    .ZERO_REG(1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rs_d          (rs_d),
    .rt_d          (rt_d),
    .uses_rt_d     (uses_rt_d),
    .rs_e          (rs_e),
    .rt_e          (rt_e),
    .rd_e          (rd_e),
    .write_reg_e   (write_reg_e),
    .load_e        (load_e),
    .branch_taken_e(branch_taken_e),
    .rd_m          (rd_m),
    .write_reg_m   (write_reg_m),
    .mem_req_m     (mem_req_m),
    .mem_ready     (mem_ready),
    .rd_w          (rd_w),
    .write_reg_w   (write_reg_w),
    .clr_cnt       (clr_cnt),
    .stall_f       (stall_f),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .flush_e       (flush_e),
    .hold_em       (hold_em),
    .fwd_a_e       (fwd_a_e),
    .fwd_b_e       (fwd_b_e),
    .mem_err       (mem_err),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Control vector order: {stall_f, stall_d, flush_d, flush_e, hold_em}
  task automatic chk_ctl(input string tag, input logic [4:0] expv);
    chk(tag, {11'd0, stall_f, stall_d, flush_d, flush_e, hold_em}, {11'd0, expv});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_d = '0; rt_d = '0; uses_rt_d = 1'b0;
    rs_e = '0; rt_e = '0; rd_e = '0; write_reg_e = 1'b0; load_e = 1'b0;
    branch_taken_e = 1'b0;
    rd_m = '0; write_reg_m = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b0;
    rd_w = '0; write_reg_w = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic set_loaduse();
    load_e = 1'b1; write_reg_e = 1'b1; rd_e = 3'd3; rs_d = 3'd3;
  endtask

  initial begin
    // ---- reset: controls forced low, forwarding still live ----
    rst = 1'b1;
    idle();
    set_loaduse();
    rs_e = 3'd2; rd_m = 3'd2; write_reg_m = 1'b1;
    #1;
    $display("step reset_hold");
    chk_ctl("rst_ctl", 5'b00000);
    chk("rst_stall_cnt", 16'(stall_cnt), 16'd0);
    chk("rst_flush_cnt", 16'(flush_cnt), 16'd0);
    chk("rst_mem_err", 16'(mem_err), 16'd0);
    chk("rst_fwd_a", 16'(fwd_a_e), 16'd2);
    tick();
    chk("rst_edge_stall_cnt", 16'(stall_cnt), 16'd0);
    rst = 1'b0;
    idle();
    #1;
    chk_ctl("idle_ctl", 5'b00000);
    tick();

    // ---- load-use on rs ----
    $display("step load_use");
    set_loaduse();
    #1;
    chk_ctl("lu_ctl", 5'b11010);
    tick();
    idle();
    chk("lu_stall_cnt", 16'(stall_cnt), 16'd1);
    #1;
    chk_ctl("lu_one_cycle", 5'b00000);

    // ---- load-use boundary cases ----
    $display("step load_use_bounds");
    load_e = 1'b1; write_reg_e = 1'b1; rd_e = 3'd0; rs_d = 3'd0;
    #1;
    chk_ctl("lu_r0", 5'b00000);
    write_reg_e = 1'b0; rd_e = 3'd3; rs_d = 3'd3;
    #1;
    chk_ctl("lu_no_wr", 5'b00000);
    write_reg_e = 1'b1; rd_e = 3'd5; rt_d = 3'd5; rs_d = 3'd1; uses_rt_d = 1'b0;
    #1;
    chk_ctl("lu_rt_unused", 5'b00000);
    uses_rt_d = 1'b1;
    #1;
    chk_ctl("lu_rt_used", 5'b11010);
    tick();
    idle();
    chk("lu_rt_stall_cnt", 16'(stall_cnt), 16'd2);

    // ---- branch beats load-use ----
    $display("step branch_vs_loaduse");
    set_loaduse();
    branch_taken_e = 1'b1;
    #1;
    chk_ctl("br_ctl", 5'b00110);
    tick();
    idle();
    chk("br_flush_cnt", 16'(flush_cnt), 16'd1);
    chk("br_stall_cnt", 16'(stall_cnt), 16'd2);

    // ---- forwarding ----
    $display("step forwarding");
    rs_e = 3'd2; rd_m = 3'd2; write_reg_m = 1'b1; rd_w = 3'd2; write_reg_w = 1'b1;
    #1;
    chk("fwd_a_m", 16'(fwd_a_e), 16'd2);
    write_reg_m = 1'b0;
    #1;
    chk("fwd_a_w", 16'(fwd_a_e), 16'd1);
    rt_e = 3'd0; rd_w = 3'd0;
    #1;
    chk("fwd_b_r0", 16'(fwd_b_e), 16'd0);
    rt_e = 3'd4; rd_m = 3'd4; write_reg_m = 1'b1;
    #1;
    chk("fwd_b_m", 16'(fwd_b_e), 16'd2);
    rs_e = 3'd0; rd_m = 3'd0; rd_w = 3'd0;
    #1;
    chk("fwd_a_r0", 16'(fwd_a_e), 16'd0);
    tick();
    idle();

    // ---- memory wait of 3 cycles with a concurrent branch ----
    $display("step mem_wait");
    mem_req_m = 1'b1; mem_ready = 1'b0; branch_taken_e = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_ctl("mw_hold", 5'b11001);
      tick();
    end
    chk("mw_stall_cnt", 16'(stall_cnt), 16'd5);
    mem_ready = 1'b1;
    #1;
    chk_ctl("mw_release", 5'b00110);
    tick();
    idle();
    chk("mw_stall_cnt_after", 16'(stall_cnt), 16'd5);
    chk("mw_mem_err", 16'(mem_err), 16'd0);

    // ---- timeout after MAX_WAIT held edges ----
    $display("step timeout");
    mem_req_m = 1'b1; mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("to_mem_err", 16'(mem_err), (i == 4) ? 16'd1 : 16'd0);
    end
    chk("to_stall_cnt", 16'(stall_cnt), 16'd9);
    mem_ready = 1'b1; mem_req_m = 1'b0; branch_taken_e = 1'b1;
    set_loaduse();
    #1;
    chk_ctl("to_stuck", 5'b11001);
    for (int i = 0; i < 8; i++) tick();
    chk("to_stall_sat", 16'(stall_cnt), 16'd15);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_stall_cnt", 16'(stall_cnt), 16'd0);
    chk("clr_flush_cnt", 16'(flush_cnt), 16'd0);
    tick();
    chk("to_stall_after_clr", 16'(stall_cnt), 16'd1);
    rst = 1'b1;
    #1;
    chk_ctl("to_rst_ctl", 5'b00000);
    chk("to_rst_mem_err", 16'(mem_err), 16'd0);
    chk("to_rst_stall_cnt", 16'(stall_cnt), 16'd0);
    rst = 1'b0;
    idle();
    #1;
    chk_ctl("to_rst_run", 5'b00000);

    // ---- async reset in the middle of a memory wait ----
    $display("step async_reset_mem_wait");
    set_loaduse();
    for (int i = 0; i < 3; i++) tick();
    idle();
    mem_req_m = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    chk("ar_stall_cnt", 16'(stall_cnt), 16'd5);
    #3;
    rst = 1'b1;
    #1;
    chk_ctl("ar_ctl", 5'b00000);
    chk("ar_stall_cnt_zero", 16'(stall_cnt), 16'd0);
    chk("ar_mem_err", 16'(mem_err), 16'd0);
    rst = 1'b0;
    #1;
    chk_ctl("ar_hold_again", 5'b11001);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("ar_to_mem_err", 16'(mem_err), (i == 4) ? 16'd1 : 16'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
